// File: rtl/cache_mem_arbiter.sv
// Arbitrates a single RAM port between an instruction-fill and a data requester.
// Data normally wins, but a waiting instruction fill is forced through after STARVE_LIMIT data grants.
module cache_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [ADDR_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic [ADDR_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  streak_q, streak_d;
    ramstate_t      ram_st;
    logic           dreq;
    logic           ram_done;
    logic           icomp;
    logic           dcomp;

    assign ram_st   = ramstate_t'(ramstate);
    assign dreq     = dREN | dWEN;
    assign ram_done = (ram_st == RAM_ACCESS);
    assign icomp    = (state_q == IGNT) && iREN && ram_done;
    assign dcomp    = (state_q == DGNT) && dreq && ram_done;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dreq && ((streak_q < LIMIT) || !iREN)) begin
                    state_d = DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                if (!iREN || icomp) begin
                    state_d = IDLE;
                end
            end
            DGNT: begin
                if (!dreq || dcomp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clearing wins over incrementing when iREN falls on a data completion.
        streak_d = streak_q;
        if (!iREN || icomp) begin
            streak_d = '0;
        end else if (dcomp && (streak_q < LIMIT)) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state_q)
            IGNT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_done) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            DGNT: begin
                if (dreq) begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ram_done) begin
                        dwait = 1'b0;
                        dload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
